serial_addsub_unit: RTL and testbench

//  Parametrised digit-serial adder/subtractor, successor to the 8-bit bit-serial adder.

---
 rtl/serial_addsub_unit.sv | 131 +++++++++++++
 tb/tb_serial_addsub_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: DIGIT bits of two WIDTH-bit operands per clock, LSB digit first.
// Optional signed-overflow output is enabled by defining SERIAL_OVF_EN.
module serial_addsub_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshake: start is taken only in IDLE; busy is high for the N RUN cycles, then done
  // pulses for one cycle while sum/cout (and ovf) are valid; they hold until the next start.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [DIGIT:0]   dig_sum;
  logic             last_step;
`ifdef SERIAL_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    dig_sum   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    last_step = (state_q == ST_RUN) && (cnt_q == LAST);
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_OVF_EN
    // The carry into the MSB is recovered from the MSB sum bit of the final digit.
    msb_cin = dig_sum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
    ovf_d   = ovf_q;
`endif
    if (state_q == ST_IDLE && start) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = cin ^ sub;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      sum_d   = WIDTH'({dig_sum[DIGIT-1:0], sum_q} >> DIGIT);
      carry_d = dig_sum[DIGIT];
      cnt_d   = cnt_q + CW'(1);
      if (last_step) begin
        cout_d = dig_sum[DIGIT];
`ifdef SERIAL_OVF_EN
        ovf_d  = msb_cin ^ dig_sum[DIGIT];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: three configurations (8/1, 8/4, 16/2) checked against an
// arithmetic reference model; ovf checks are active when SERIAL_OVF_EN is defined.
module tb_serial_addsub_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_m = 1'b0, start_4 = 1'b0, start_16 = 1'b0;
  logic        sub = 1'b0, cin = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;

  logic        busy_m, done_m, cout_m, ovf_m;
  logic [7:0]  sum_m;
  logic        busy_4, done_4, cout_4, ovf_4;
  logic [7:0]  sum_4;
  logic        busy_16, done_16, cout_16, ovf_16;
  logic [15:0] sum_16;

  int n_cmp = 0;
  int n_err = 0;
  int sel = 0;

  logic        busy_s, done_s, cout_s, ovf_s;
  logic [15:0] sum_s;

  always #5 clk = ~clk;

  serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) dut_m (
    .clk(clk), .rst(rst), .start(start_m), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin),
    .busy(busy_m), .done(done_m), .sum(sum_m), .cout(cout_m)
`ifdef SERIAL_OVF_EN
    , .ovf(ovf_m)
`endif
  );

  serial_addsub_unit #(.WIDTH(8), .DIGIT(4)) dut_4 (
    .clk(clk), .rst(rst), .start(start_4), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin),
    .busy(busy_4), .done(done_4), .sum(sum_4), .cout(cout_4)
`ifdef SERIAL_OVF_EN
    , .ovf(ovf_4)
`endif
  );

  serial_addsub_unit #(.WIDTH(16), .DIGIT(2)) dut_16 (
    .clk(clk), .rst(rst), .start(start_16), .sub(sub), .a(a_in), .b(b_in), .cin(cin),
    .busy(busy_16), .done(done_16), .sum(sum_16), .cout(cout_16)
`ifdef SERIAL_OVF_EN
    , .ovf(ovf_16)
`endif
  );

`ifndef SERIAL_OVF_EN
  assign ovf_m  = 1'b0;
  assign ovf_4  = 1'b0;
  assign ovf_16 = 1'b0;
`endif

  always_comb begin
    busy_s = busy_m; done_s = done_m; cout_s = cout_m; ovf_s = ovf_m; sum_s = {8'h00, sum_m};
    if (sel == 1) begin
      busy_s = busy_4; done_s = done_4; cout_s = cout_4; ovf_s = ovf_4; sum_s = {8'h00, sum_4};
    end else if (sel == 2) begin
      busy_s = busy_16; done_s = done_16; cout_s = cout_16; ovf_s = ovf_16; sum_s = sum_16;
    end
  end

  function automatic int width_of(input int s);
    return (s == 2) ? 16 : 8;
  endfunction

  function automatic int n_of(input int s);
    return (s == 1) ? 2 : 8;
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input logic s, input logic [15:0] ia, input logic [15:0] ib,
                                input logic c, output logic [15:0] es, output logic ec, output logic eo);
    longint m, ua, ub, sa, sb, t, r, lc;
    m  = longint'(1) << w;
    lc = longint'(c);
    ua = longint'(ia) & (m - 1);
    ub = longint'(ib) & (m - 1);
    if (!s) begin
      t  = ua + ub + lc;
      ec = (t >= m);
    end else begin
      t  = ua - ub - lc;
      ec = (ua >= ub + lc);
    end
    es = 16'(t & (m - 1));
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = s ? (sa - sb - lc) : (sa + sb + lc);
    eo = (r >= m / 2) || (r < -(m / 2));
  endfunction

  task automatic set_start(input int s, input logic v);
    start_m  = (s == 0) ? v : 1'b0;
    start_4  = (s == 1) ? v : 1'b0;
    start_16 = (s == 2) ? v : 1'b0;
  endtask

  // Drives one operation and reports what was observed; callers do the comparisons.
  task automatic run_op(input int s, input logic isub, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input bit poke, output int lat, output int bcnt,
                        output logic [15:0] osum, output logic ocout, output logic oovf,
                        output logic done_after);
    sel = s;
    @(negedge clk);
    sub = isub; a_in = ia; b_in = ib; cin = ic;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    a_in = 16'($urandom); b_in = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    lat = 0; bcnt = 0;
    while (done_s !== 1'b1 && lat < 40) begin
      if (busy_s === 1'b1) bcnt++;
      set_start(s, (poke && lat == 2) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    set_start(s, 1'b0);
    osum = sum_s; ocout = cout_s; oovf = ovf_s;
    @(posedge clk); #1;
    done_after = done_s;
  endtask

  task automatic test_reset;
    rst = 1'b1; set_start(0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b expected 0", busy_m); end
    n_cmp++; if (done_m !== 1'b0) begin n_err++; $display("FAIL reset_done got %b expected 0", done_m); end
    n_cmp++; if (sum_m !== 8'h00) begin n_err++; $display("FAIL reset_sum got %h expected 00", sum_m); end
    n_cmp++; if (cout_m !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b expected 0", cout_m); end
`ifdef SERIAL_OVF_EN
    n_cmp++; if (ovf_m !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b expected 0", ovf_m); end
`endif
    n_cmp++; if (busy_16 !== 1'b0) begin n_err++; $display("FAIL reset_busy16 got %b expected 0", busy_16); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_op(input string name, input int s, input logic isub, input logic [15:0] ia,
                          input logic [15:0] ib, input logic ic, input bit poke);
    int lat, bcnt;
    logic [15:0] osum, es;
    logic ocout, oovf, dafter, ec, eo;
    model(width_of(s), isub, ia, ib, ic, es, ec, eo);
    run_op(s, isub, ia, ib, ic, poke, lat, bcnt, osum, ocout, oovf, dafter);
    n_cmp++; if (lat != n_of(s)) begin n_err++; $display("FAIL %s latency got %0d expected %0d", name, lat, n_of(s)); end
    n_cmp++; if (bcnt != n_of(s)) begin n_err++; $display("FAIL %s busy_cycles got %0d expected %0d", name, bcnt, n_of(s)); end
    n_cmp++; if (osum !== es) begin n_err++; $display("FAIL %s sum got %h expected %h", name, osum, es); end
    n_cmp++; if (ocout !== ec) begin n_err++; $display("FAIL %s cout got %b expected %b", name, ocout, ec); end
    n_cmp++; if (dafter !== 1'b0) begin n_err++; $display("FAIL %s done_width got %b expected 0", name, dafter); end
`ifdef SERIAL_OVF_EN
    n_cmp++; if (oovf !== eo) begin n_err++; $display("FAIL %s ovf got %b expected %b", name, oovf, eo); end
`endif
  endtask

  task automatic test_add;
    check_op("add_5a_3c", 0, 1'b0, 16'h5A, 16'h3C, 1'b0, 1'b0);
    n_cmp++; if (sum_m !== 8'h96) begin n_err++; $display("FAIL add_const sum got %h expected 96", sum_m); end
    check_op("add_ff_01", 0, 1'b0, 16'hFF, 16'h01, 1'b0, 1'b0);
    n_cmp++; if ({cout_m, sum_m} !== 9'h100) begin n_err++; $display("FAIL add_wrap got %h expected 100", {cout_m, sum_m}); end
    check_op("add_ff_01_cin", 0, 1'b0, 16'hFF, 16'h01, 1'b1, 1'b0);
    n_cmp++; if ({cout_m, sum_m} !== 9'h101) begin n_err++; $display("FAIL add_wrap_cin got %h expected 101", {cout_m, sum_m}); end
  endtask

  task automatic test_sub;
    check_op("sub_10_20", 0, 1'b1, 16'h10, 16'h20, 1'b0, 1'b0);
    n_cmp++; if ({cout_m, sum_m} !== 9'h0F0) begin n_err++; $display("FAIL sub_borrow got %h expected 0f0", {cout_m, sum_m}); end
    check_op("sub_20_10_bin", 0, 1'b1, 16'h20, 16'h10, 1'b1, 1'b0);
    n_cmp++; if ({cout_m, sum_m} !== 9'h10F) begin n_err++; $display("FAIL sub_noborrow got %h expected 10f", {cout_m, sum_m}); end
  endtask

  task automatic test_digit_variants;
    check_op("d4_5a_3c", 1, 1'b0, 16'h5A, 16'h3C, 1'b0, 1'b0);
    n_cmp++; if (sum_4 !== 8'h96) begin n_err++; $display("FAIL d4_const sum got %h expected 96", sum_4); end
    check_op("d2_1234_0fff", 2, 1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    n_cmp++; if (sum_16 !== 16'h2233) begin n_err++; $display("FAIL d2_const sum got %h expected 2233", sum_16); end
  endtask

`ifdef SERIAL_OVF_EN
  task automatic test_ovf;
    check_op("ovf_7f_01", 0, 1'b0, 16'h7F, 16'h01, 1'b0, 1'b0);
    n_cmp++; if ({ovf_m, sum_m} !== 9'h180) begin n_err++; $display("FAIL ovf_add got %h expected 180", {ovf_m, sum_m}); end
    check_op("ovf_80_01", 0, 1'b1, 16'h80, 16'h01, 1'b0, 1'b0);
    n_cmp++; if ({ovf_m, sum_m} !== 9'h17F) begin n_err++; $display("FAIL ovf_sub got %h expected 17f", {ovf_m, sum_m}); end
    check_op("ovf_05_03", 0, 1'b0, 16'h05, 16'h03, 1'b0, 1'b0);
    n_cmp++; if (ovf_m !== 1'b0) begin n_err++; $display("FAIL ovf_none got %b expected 0", ovf_m); end
  endtask
`endif

  task automatic test_start_ignored;
    check_op("poke_5a_3c", 0, 1'b0, 16'h5A, 16'h3C, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL poke_no_queue busy got %b expected 0", busy_m); end
    n_cmp++; if (sum_m !== 8'h96) begin n_err++; $display("FAIL poke_hold sum got %h expected 96", sum_m); end
    n_cmp++; if (cout_m !== 1'b0) begin n_err++; $display("FAIL poke_hold cout got %b expected 0", cout_m); end
  endtask

  task automatic test_abort;
    int pulses;
    sel = 0;
    @(negedge clk);
    a_in = 16'hC3; b_in = 16'h77; sub = 1'b0; cin = 1'b1; set_start(0, 1'b1);
    @(posedge clk); #1; set_start(0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b expected 0", busy_m); end
    n_cmp++; if (sum_m !== 8'h00) begin n_err++; $display("FAIL abort_sum got %h expected 00", sum_m); end
    n_cmp++; if (cout_m !== 1'b0) begin n_err++; $display("FAIL abort_cout got %b expected 0", cout_m); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_m === 1'b1 || busy_m === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL abort_quiet activity got %0d expected 0", pulses); end
  endtask

  task automatic test_rst_start_same;
    @(negedge clk);
    rst = 1'b1; set_start(0, 1'b1); a_in = 16'h11; b_in = 16'h22;
    @(posedge clk); #1;
    rst = 1'b0; set_start(0, 1'b0);
    @(posedge clk); #1;
    n_cmp++; if (busy_m !== 1'b0) begin n_err++; $display("FAIL rst_wins busy got %b expected 0", busy_m); end
    n_cmp++; if (sum_m !== 8'h00) begin n_err++; $display("FAIL rst_wins sum got %h expected 00", sum_m); end
  endtask

  task automatic test_back_to_back;
    check_op("b2b_first", 0, 1'b0, 16'h01, 16'h02, 1'b0, 1'b0);
    check_op("b2b_second", 0, 1'b1, 16'h03, 16'h09, 1'b1, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      check_op("rand", $urandom_range(0, 2), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_digit_variants();
`ifdef SERIAL_OVF_EN
    test_ovf();
`endif
    test_start_ignored();
    test_abort();
    test_rst_start_same();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
